sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Three-port arbiter that shares the single SDRAM controller port between the graphics system (port 0, framebuffer/scanout), the processor (port 1) and the SD-card loader (port 2). It sits in Top between the requesters and the SDRAM controller, accepts one transaction at a time, forwards it, and routes the completion back to the owning requester. A single transaction is outstanding at any time; no reordering.

## Interface
Parameters:
- ADDR_WIDTH, 24, word address width (16M x 16-bit device, 32-bit access = word pair)
- DATA_WIDTH, 32, data width per transaction
- MASK_WIDTH, DATA_WIDTH/8, byte-enable width

Ports (per-port signals are packed arrays indexed [2:0]):
- clk  in  1  system clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  3  requester i has a transaction pending
- req_write  in  3  1 = write, 0 = read
- req_addr  in  3xADDR_WIDTH  word address
- req_wdata  in  3xDATA_WIDTH  write data
- req_wmask  in  3xMASK_WIDTH  byte enables, writes only
- req_ready  out  3  one-cycle accept pulse to requester i
- rsp_valid  out  3  one-cycle completion pulse to requester i
- rsp_rdata  out  DATA_WIDTH  read data, shared, valid with rsp_valid
- mem_valid  out  1  transaction presented to controller
- mem_ready  in  1  controller accepts (valid && ready)
- mem_write, mem_addr, mem_wdata, mem_wmask  out  as requester fields
- mem_done  in  1  controller completion pulse (reads and writes)
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_done

## Operation
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE: if any req_valid, pick winner, latch its write/addr/wdata/wmask into mem_* registers and owner index, pulse req_ready[winner], go ISSUE. Else stay.
- ISSUE: mem_valid = 1, fields stable; on mem_ready go WAIT_DONE.
- WAIT_DONE: on mem_done, pulse rsp_valid[owner], register mem_rdata into rsp_rdata (write: rsp_rdata unchanged), advance round-robin pointer past owner, go IDLE.
- Round-robin: pointer rr (2 bits, values 0..2, wraps 2 -> 0); search order rr, rr+1, rr+2 mod 3. Reset rr = 0.
- Requesters may drop req_valid only after req_ready; req_valid low before grant is legal (request withdrawn, not granted).
- mem_done seen in IDLE or ISSUE is a protocol error: ignored, no rsp_valid.
- mem_ready and mem_done in the same cycle in ISSUE: treated as accept then immediate completion; rsp_valid next cycle, back to IDLE.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, mem_valid = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0, mem_wmask = 0, state = IDLE, rr = 0.
- req_valid sampled high in IDLE at cycle N: req_ready pulse and mem_valid both high from cycle N+1.
- mem_done at cycle M: rsp_valid and rsp_rdata at M+1; state IDLE at M+1; next grant earliest M+1 (decision), mem_valid M+2.
- Minimum turnaround per transaction: 3 cycles plus controller latency.
- Reset asserted mid-transaction: all outputs return to reset values immediately; in-flight transaction is abandoned, no rsp_valid; the controller must be reset together.

## Configuration
- SDRAM_ARB_GPU_PRIORITY_EN defined: port 0 wins in IDLE whenever req_valid[0] is high, regardless of rr; ports 1/2 round-robin among themselves (rr skips 0). Prevents scanout underflow.
- Not defined: pure three-way round-robin as above.

## Structure
- Shared package sdram_arb_pkg: typedef arb_state_t (IDLE, ISSUE, WAIT_DONE), constants PORT_GPU = 0, PORT_CPU = 1, PORT_SD = 2, NUM_PORTS = 3.
- One sub-module: sdram_arb_rr_pick (combinational, req_valid + rr -> winner index + any_valid), so the priority variant is isolated.

## Test plan
- Single CPU read addr 0x000100, controller returns 0xDEADBEEF after 5 cycles -> req_ready[1] at N+1, mem_addr 0x000100, rsp_valid[1] with rsp_rdata 0xDEADBEEF one cycle after mem_done.
- All three ports requesting continuously, macro off -> grant order 0,1,2,0,1,2; no port gets two grants before others.
- Same stimulus, SDRAM_ARB_GPU_PRIORITY_EN defined -> port 0 granted every transaction while valid; when port 0 idles, order 1,2,1,2.
- Write port 2 addr 0xFFFFFF, wdata 0x12345678, wmask 0b0011, mem_ready held low 10 cycles -> mem_* stable all 10 cycles, rsp_valid[2] after mem_done, rsp_rdata unchanged.
- mem_ready and mem_done same cycle -> rsp_valid next cycle, no extra mem_valid cycle.
- rst_n low while in WAIT_DONE -> all outputs zero immediately; spurious mem_done after reset produces no rsp_valid.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the three-port SDRAM arbiter.
// Optional feature macro used by the slice: SDRAM_ARB_GPU_PRIORITY_EN.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int         NUM_PORTS = 3;
  localparam logic [1:0] PORT_GPU  = 2'd0;
  localparam logic [1:0] PORT_CPU  = 2'd1;
  localparam logic [1:0] PORT_SD   = 2'd2;

  // Port index that follows p in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    case (p)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// Combinational winner selection for the SDRAM arbiter.
// SDRAM_ARB_GPU_PRIORITY_EN: port 0 always wins, ports 1/2 rotate between themselves.
module sdram_arb_rr_pick
  import sdram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_valid,
  input  logic [1:0]           rr,
  output logic [1:0]           winner,
  output logic                 any_valid
);

`ifdef SDRAM_ARB_GPU_PRIORITY_EN
  // GPU has absolute priority; rr only orders CPU against SD.
  always_comb begin
    any_valid = |req_valid;
    if (req_valid[PORT_GPU]) begin
      winner = PORT_GPU;
    end else if (rr == PORT_SD) begin
      winner = req_valid[PORT_SD] ? PORT_SD : PORT_CPU;
    end else begin
      winner = req_valid[PORT_CPU] ? PORT_CPU : PORT_SD;
    end
  end
`else
  logic [1:0] cand_s;
  logic       hit_s;

  // Walk rr, rr+1, rr+2 (mod 3) and keep the first requester found.
  always_comb begin
    winner    = rr;
    any_valid = 1'b0;
    cand_s    = rr;
    hit_s     = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      hit_s     = !any_valid && req_valid[cand_s];
      winner    = hit_s ? cand_s : winner;
      any_valid = any_valid | hit_s;
      cand_s    = next_port(cand_s);
    end
  end
`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between GPU, CPU and SD loader, one transaction at a time.
// Arbitration policy selected by SDRAM_ARB_GPU_PRIORITY_EN (see sdram_arb_rr_pick).
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  req_valid,
  input  logic [NUM_PORTS-1:0]                  req_write,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_PORTS-1:0][MASK_WIDTH-1:0]  req_wmask,
  output logic [NUM_PORTS-1:0]                  req_ready,
  output logic [NUM_PORTS-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata,
  output logic                                  mem_valid,
  input  logic                                  mem_ready,
  output logic                                  mem_write,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  output logic [MASK_WIDTH-1:0]                 mem_wmask,
  input  logic                                  mem_done,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata
);

  arb_state_t                state_r, state_nxt_s;
  logic [1:0]                rr_r, rr_nxt_s;
  logic [1:0]                owner_r, owner_nxt_s;
  logic [NUM_PORTS-1:0]      req_ready_r, req_ready_nxt_s;
  logic [NUM_PORTS-1:0]      rsp_valid_r, rsp_valid_nxt_s;
  logic [DATA_WIDTH-1:0]     rsp_rdata_r, rsp_rdata_nxt_s;
  logic                      mem_valid_r, mem_valid_nxt_s;
  logic                      mem_write_r, mem_write_nxt_s;
  logic [ADDR_WIDTH-1:0]     mem_addr_r, mem_addr_nxt_s;
  logic [DATA_WIDTH-1:0]     mem_wdata_r, mem_wdata_nxt_s;
  logic [MASK_WIDTH-1:0]     mem_wmask_r, mem_wmask_nxt_s;
  logic [1:0]                winner_s;
  logic                      any_valid_s;
  logic                      complete_s;

  sdram_arb_rr_pick u_pick (
    .req_valid (req_valid),
    .rr        (rr_r),
    .winner    (winner_s),
    .any_valid (any_valid_s)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt_s     = state_r;
    rr_nxt_s        = rr_r;
    owner_nxt_s     = owner_r;
    req_ready_nxt_s = '0;
    rsp_valid_nxt_s = '0;
    rsp_rdata_nxt_s = rsp_rdata_r;
    mem_valid_nxt_s = mem_valid_r;
    mem_write_nxt_s = mem_write_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    mem_wmask_nxt_s = mem_wmask_r;
    complete_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_valid_s) begin
          owner_nxt_s               = winner_s;
          req_ready_nxt_s[winner_s] = 1'b1;
          mem_valid_nxt_s           = 1'b1;
          mem_write_nxt_s           = req_write[winner_s];
          mem_addr_nxt_s            = req_addr[winner_s];
          mem_wdata_nxt_s           = req_wdata[winner_s];
          mem_wmask_nxt_s           = req_wmask[winner_s];
          state_nxt_s               = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        // A done arriving with the accept completes the transaction at once.
        if (mem_ready) begin
          mem_valid_nxt_s = 1'b0;
          complete_s      = mem_done;
          state_nxt_s     = mem_done ? IDLE : WAIT_DONE;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT_DONE: begin
        complete_s  = mem_done;
        state_nxt_s = mem_done ? IDLE : WAIT_DONE;
      end
      default: begin
        mem_valid_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
    endcase
    if (complete_s) begin
      rsp_valid_nxt_s[owner_r] = 1'b1;
      rsp_rdata_nxt_s          = mem_write_r ? rsp_rdata_r : mem_rdata;
      rr_nxt_s                 = next_port(owner_r);
    end else begin
      rr_nxt_s = rr_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_r        <= 2'd0;
      owner_r     <= 2'd0;
      req_ready_r <= '0;
      rsp_valid_r <= '0;
      rsp_rdata_r <= '0;
      mem_valid_r <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_wmask_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      rr_r        <= rr_nxt_s;
      owner_r     <= owner_nxt_s;
      req_ready_r <= req_ready_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
      mem_valid_r <= mem_valid_nxt_s;
      mem_write_r <= mem_write_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      mem_wmask_r <= mem_wmask_nxt_s;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign mem_valid = mem_valid_r;
  assign mem_write = mem_write_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wmask = mem_wmask_r;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: vector table with a response scoreboard,
// plus hand-written round-robin and reset-in-flight sequences.
module tb_sdram_port_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int MW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        req_valid, req_write;
  logic [2:0][AW-1:0] req_addr;
  logic [2:0][DW-1:0] req_wdata;
  logic [2:0][MW-1:0] req_wmask;
  logic [2:0]        req_ready, rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              mem_valid, mem_ready, mem_write, mem_done;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic [MW-1:0]     mem_wmask;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [1:0]    port;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic [DW-1:0] rdata;
    int            stall;
    int            lat;
    logic          same;
    logic          spurious;
  } vec_t;

  typedef struct {
    logic [1:0]    port;
    logic [DW-1:0] rdata;
  } exp_t;

  vec_t          vecs[6];
  exp_t          sb_q[$];
  logic [DW-1:0] model_rdata;
  logic [1:0]    order[10];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 3'b000);
    check({tag, "_rsp_valid"}, rsp_valid, 3'b000);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_mem_valid"}, mem_valid, 1'b0);
    check({tag, "_mem_write"}, mem_write, 1'b0);
    check({tag, "_mem_addr"},  mem_addr,  24'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_mem_wmask"}, mem_wmask, 4'h0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    req_valid[v.port] = 1'b1;
    req_write[v.port] = v.write;
    req_addr[v.port]  = v.addr;
    req_wdata[v.port] = v.wdata;
    req_wmask[v.port] = v.wmask;
    e.port  = v.port;
    e.rdata = v.write ? model_rdata : v.rdata;
    model_rdata = e.rdata;
    sb_q.push_back(e);
    tick();
    check("grant_ready", req_ready, 3'b001 << v.port);
    check("grant_mem_valid", mem_valid, 1'b1);
    check("grant_mem_write", mem_write, v.write);
    check("grant_mem_addr", mem_addr, v.addr);
    check("grant_mem_wdata", mem_wdata, v.wdata);
    check("grant_mem_wmask", mem_wmask, v.wmask);
    req_valid[v.port] = 1'b0;
    for (int i = 0; i < v.stall; i++) begin
      mem_done  = v.spurious && (i == 0);
      mem_rdata = 32'hBAD0_BAD0;
      tick();
      mem_done = 1'b0;
      check("stall_mem_valid", mem_valid, 1'b1);
      check("stall_mem_fields", {mem_write, mem_addr, mem_wdata, mem_wmask},
            {v.write, v.addr, v.wdata, v.wmask});
      check("stall_rsp_valid", rsp_valid, 3'b000);
    end
    mem_ready = 1'b1;
    mem_done  = v.same;
    mem_rdata = v.rdata;
    tick();
    mem_ready = 1'b0;
    mem_done  = 1'b0;
    check("accept_mem_valid", mem_valid, 1'b0);
    if (!v.same) begin
      for (int i = 0; i < v.lat; i++) begin
        tick();
        check("wait_rsp_valid", rsp_valid, 3'b000);
      end
      mem_done  = 1'b1;
      mem_rdata = v.rdata;
      tick();
      mem_done = 1'b0;
    end
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries, required 1");
    end else begin
      e = sb_q.pop_front();
      check("rsp_valid", rsp_valid, 3'b001 << e.port);
      check("rsp_rdata", rsp_rdata, e.rdata);
    end
    tick();
    check("rsp_pulse_end", rsp_valid, 3'b000);
    check("ready_pulse_end", req_ready, 3'b000);
  endtask

  task automatic wait_grant(output logic [1:0] g);
    bit ok;
    ok = 1'b0;
    g  = 2'd0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (req_ready != 3'b000) begin
        ok = 1'b1;
        g  = req_ready[1] ? 2'd1 : (req_ready[2] ? 2'd2 : 2'd0);
      end
    end
    check("grant_seen", ok, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] g;
    vecs[0] = '{2'd1, 1'b0, 24'h000100, 32'h0,         4'h0, 32'hDEADBEEF, 0,  5, 1'b0, 1'b0};
    vecs[1] = '{2'd2, 1'b1, 24'hFFFFFF, 32'h12345678,  4'h3, 32'h5555AAAA, 10, 2, 1'b0, 1'b1};
    vecs[2] = '{2'd0, 1'b0, 24'h000000, 32'h0,         4'h0, 32'hA5A50F0F, 1,  0, 1'b1, 1'b0};
    vecs[3] = '{2'd1, 1'b1, 24'h0ABCDE, 32'hCAFEF00D,  4'hF, 32'h11112222, 0,  3, 1'b0, 1'b0};
    vecs[4] = '{2'd0, 1'b0, 24'h123456, 32'h0,         4'h0, 32'h00000000, 2,  1, 1'b0, 1'b0};
    vecs[5] = '{2'd2, 1'b0, 24'h7FFFFF, 32'h0,         4'h0, 32'hFFFFFFFF, 0,  0, 1'b1, 1'b0};
`ifdef SDRAM_ARB_GPU_PRIORITY_EN
    order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2};
`else
    order = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
`endif
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    model_rdata = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // All three ports requesting back to back, then GPU goes quiet.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      req_addr[p]  = 24'h000010 + 24'(p);
      req_write[p] = 1'b0;
    end
    req_valid = 3'b111;
    for (int k = 0; k < 10; k++) begin
      if (k == 6) req_valid = 3'b110;
      wait_grant(g);
      check("rr_onehot", $countones(req_ready), 1);
      check("rr_order", g, order[k]);
      check("rr_mem_addr", mem_addr, 24'h000010 + 24'(g));
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      mem_done  = 1'b1;
      mem_rdata = 32'h100 + 32'(k);
      tick();
      mem_done = 1'b0;
      check("rr_rsp_valid", rsp_valid, 3'b001 << g);
      check("rr_rsp_rdata", rsp_rdata, 32'h100 + 32'(k));
    end
    req_valid = 3'b000;
    tick();
    tick();

    // Reset while waiting for completion, then a stray done afterwards.
    req_valid[1] = 1'b1; req_write[1] = 1'b0;
    req_addr[1] = 24'h000ABC; req_wdata[1] = 32'h0F0F0F0F; req_wmask[1] = 4'hF;
    tick();
    check("inflight_grant", req_ready, 3'b010);
    req_valid[1] = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    rst_n = 1'b1;
    mem_done = 1'b1;
    mem_rdata = 32'h77777777;
    tick();
    mem_done = 1'b0;
    check("stray_done_rsp", rsp_valid, 3'b000);
    tick();
    check("stray_done_rsp2", rsp_valid, 3'b000);
    check("stray_done_rdata", rsp_rdata, 32'h0);
    check("stray_done_mem_valid", mem_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
